// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction-fetch stage.
//   - INSTR_W         : instruction / address width (only 32 is supported)
//   - IF_NOP_INSTR    : bubble instruction (addi x0,x0,0)
//   - IF_RESET_PC     : default first fetch address after reset
//   - fetch_state_e   : fetch FSM state encoding
//   - align_word()    : clears the two byte-offset bits of an address
package if_stage_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pend.sv
// if_pend_buf: one-entry holding register for a fetched instruction that
// arrived while the IF/ID register was occupied and stalled.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load_i              : capture instr_i/pc_i and mark the entry valid
//   drain_i             : entry has been moved to IF/ID, mark it empty
//   clear_i             : squash the entry (flush)
//   instr_i, pc_i       : instruction and its PC to capture
//   instr_o, pc_o       : held instruction and PC
//   valid_o             : entry holds a real instruction
module if_pend_buf
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               drain_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [INSTR_W-1:0] pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] pc_o,
  output logic               valid_o
);

  // Clear and drain both empty the entry; they win over a load, which the
  // fetch stage never issues in the same cycle anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      instr_o <= '0;
      pc_o    <= '0;
    end else if (clear_i || drain_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      instr_o <= instr_i;
      pc_o    <= pc_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Holds the PC, fetches one instruction
// at a time over a req/gnt/rvalid memory interface (at most one request in
// flight) and produces the IF/ID register consumed by decode.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   stall_i, flush_i           : hazard unit hold / squash of IF/ID
//   redirect_i, redirect_pc_i  : taken branch or jump target from EX
//   imem_req_o, imem_addr_o    : fetch request and word-aligned address
//   imem_gnt_i                 : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i: response (no back-pressure)
//   ID_instr_o, ID_pc_o        : IF/ID instruction and its PC
//   ID_valid_o                 : IF/ID holds a real instruction
// Optional feature (macro IF_PERF_CNT_EN): adds perf_fetch_cnt_o and
// perf_bubble_cnt_o, free-running 32-bit event counters.
// DATA_WIDTH must be 32.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR  = IF_NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] ID_instr_o,
  output logic [DATA_WIDTH-1:0] ID_pc_o,
  output logic                  ID_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt_o,
  output logic [31:0]           perf_bubble_cnt_o
`endif
);

  fetch_state_e          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] req_pc;

  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_instr;
  logic [DATA_WIDTH-1:0] pend_pc;

  logic fetch_fire;
  logic deliver;
  logic slot_free;
  logic pend_load;
  logic pend_drain;

  // No new request while a parked instruction waits; this bounds the
  // stage to two buffered instructions (IF/ID plus pend).
  assign imem_req_o  = (state == S_REQ) && !pend_valid;
  assign imem_addr_o = pc;
  assign fetch_fire  = imem_req_o && imem_gnt_i;

  // A response counts only in S_WAIT and only if no redirect arrives with it.
  assign deliver    = (state == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign slot_free  = !ID_valid_o || !stall_i;
  assign pend_load  = deliver && !slot_free && !flush_i;
  assign pend_drain = pend_valid && !stall_i;

  // Fetch FSM. A redirect is applied after the case so its target overrides
  // the pc+4 increment of a same-cycle grant. In S_DROP a response that
  // coincides with a redirect still retires the stale request, so the FSM
  // returns to S_REQ rather than waiting for a response that never comes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= align_word(RESET_PC);
      req_pc <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (fetch_fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= redirect_i ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i)   state <= S_REQ;
          else if (redirect_i) state <= S_DROP;
        end
        S_DROP: begin
          if (imem_rvalid_i) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
      if (redirect_i) pc <= align_word(redirect_pc_i);
    end
  end

  // IF/ID register. Flush beats everything; a parked instruction is older
  // than anything arriving now, so it drains first; otherwise an idle,
  // unstalled cycle loads a bubble while keeping the last PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_valid_o <= 1'b0;
      ID_instr_o <= NOP_INSTR;
      ID_pc_o    <= '0;
    end else if (flush_i) begin
      ID_valid_o <= 1'b0;
      ID_instr_o <= NOP_INSTR;
    end else if (pend_drain) begin
      ID_valid_o <= 1'b1;
      ID_instr_o <= pend_instr;
      ID_pc_o    <= pend_pc;
    end else if (deliver && slot_free) begin
      ID_valid_o <= 1'b1;
      ID_instr_o <= imem_rdata_i;
      ID_pc_o    <= req_pc;
    end else if (!stall_i) begin
      ID_valid_o <= 1'b0;
      ID_instr_o <= NOP_INSTR;
    end
  end

  if_pend_buf u_pend (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (pend_load),
    .drain_i (pend_drain),
    .clear_i (flush_i),
    .instr_i (imem_rdata_i),
    .pc_i    (req_pc),
    .instr_o (pend_instr),
    .pc_o    (pend_pc),
    .valid_o (pend_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic fetch_evt;
  logic bubble_evt;

  // Bubble events mirror the flush and idle-bubble branches of IF/ID.
  assign fetch_evt  = deliver && !flush_i;
  assign bubble_evt = flush_i || (!stall_i && !pend_valid && !deliver);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_o  <= '0;
      perf_bubble_cnt_o <= '0;
    end else begin
      if (fetch_evt)  perf_fetch_cnt_o  <= perf_fetch_cnt_o + 32'd1;
      if (bubble_evt) perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized bench for if_stage. A memory model grants and
// answers requests with random latency; responses that survive (no
// redirect between grant and response, no flush in the response cycle)
// are queued as expected IF/ID contents, flush empties the queue, and a
// monitor pops and compares every instruction that decode consumes.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] ID_instr_o;
  logic [31:0] ID_pc_o;
  logic        ID_valid_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_bubble_cnt_o;
`endif

  always #5 clk = ~clk;

  if_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .ID_instr_o    (ID_instr_o),
    .ID_pc_o       (ID_pc_o),
    .ID_valid_o    (ID_valid_o)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o  (perf_fetch_cnt_o),
    .perf_bubble_cnt_o (perf_bubble_cnt_o)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  item_t       exp_q[$];

  // Memory-model state for the single outstanding request.
  bit          busy = 1'b0;
  bit          busy_stale = 1'b0;
  int          lat = 0;
  logic [31:0] busy_addr = '0;
  logic [31:0] next_pc = 32'h0000_0000;

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive hazard/redirect inputs, let the memory
  // model answer or grant, and keep the expected queue and next PC current.
  task automatic applyStimulus(input logic st, input logic fl, input logic rd,
                               input logic [31:0] tgt, input bit allow_gnt);
    bit gnt;
    bit was_busy;
    @(negedge clk);
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    if (fl) exp_q.delete();
    was_busy = busy;
    if (busy) begin
      if (lat == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = memData(busy_addr);
        busy          = 1'b0;
        if (!busy_stale && !rd && !fl)
          exp_q.push_back('{instr: memData(busy_addr), pc: busy_addr});
      end else begin
        lat--;
      end
    end
    gnt        = allow_gnt && ($urandom_range(0, 3) != 0);
    imem_gnt_i = gnt;
    if (gnt && imem_req_o) begin
      checkOutput("one_outstanding", {31'd0, was_busy}, 32'd0);
      checkOutput("fetch_addr", imem_addr_o, next_pc);
      busy       = 1'b1;
      busy_stale = rd;
      busy_addr  = next_pc;
      lat        = $urandom_range(0, 2);
      next_pc    = next_pc + 32'd4;
    end
    if (rd) begin
      next_pc = {tgt[31:2], 2'b00};
      if (busy) busy_stale = 1'b1;
    end
  endtask

  // Reset with a response driven while reset is low and another one in the
  // first (idle) cycle after release; neither may reach IF/ID.
  task automatic resetDut();
    @(negedge clk);
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h1234_5678;
    busy          = 1'b0;
    busy_stale    = 1'b0;
    next_pc       = 32'h0000_0000;
    exp_q.delete();
    #1;
    checkOutput("rst_valid", ID_valid_o, 32'd0);
    checkOutput("rst_instr", ID_instr_o, 32'h0000_0013);
    checkOutput("rst_pc", ID_pc_o, 32'd0);
    checkOutput("rst_req", imem_req_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_req", imem_req_o, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("first_req", imem_req_o, 32'd1);
    checkOutput("first_addr", imem_addr_o, 32'h0000_0000);
    checkOutput("idle_rvalid_ignored", ID_valid_o, 32'd0);
  endtask

  // Monitor: decode consumes IF/ID whenever it is valid and neither stalled
  // nor flushed; every consumed instruction must be the oldest expected one.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (ID_valid_o && !stall_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL consume_unexpected: got pc %h instr %h expected none",
                   ID_pc_o, ID_instr_o);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          checkOutput("id_instr", ID_instr_o, e.instr);
          checkOutput("id_pc", ID_pc_o, e.pc);
          consumed++;
        end
      end
      if (!ID_valid_o) checkOutput("bubble_nop", ID_instr_o, 32'h0000_0013);
    end
  end

  initial begin
    resetDut();

    // Randomized traffic: alternating heavy-stall and light-stall phases,
    // with redirect targets sometimes near the top of the address space so
    // the PC wraps through 0.
    for (int i = 0; i < 4000; i++) begin
      logic        st;
      logic        fl;
      logic        rd;
      logic [31:0] tgt;
      st  = ((i % 800) < 400) ? ($urandom_range(0, 1) == 0)
                              : ($urandom_range(0, 5) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 2047));
      applyStimulus(st, fl, rd, tgt, 1'b1);
    end

    // Long stall: IF/ID and pend fill, then fetching must stop.
    repeat (25) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("stall_valid_held", ID_valid_o, 32'd1);
    checkOutput("pend_blocks_req", imem_req_o, 32'd0);
    if (exp_q.size() > 0) checkOutput("stall_pc_held", ID_pc_o, exp_q[0].pc);

    // Flush together with stall: both entries squashed, fetch resumes.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("flush_valid", ID_valid_o, 32'd0);
    checkOutput("flush_instr", ID_instr_o, 32'h0000_0013);
    checkOutput("flush_pend_cleared", imem_req_o, 32'd1);
    repeat (200) applyStimulus(($urandom_range(0, 3) == 0), 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset while a request is in flight.
    for (int n = 0; n < 20 && !busy; n++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("inflight_before_reset", {31'd0, busy}, 32'd1);
    resetDut();
    repeat (300) applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
                               ($urandom_range(0, 15) == 0), 32'($urandom_range(0, 1023)),
                               1'b1);

    // Drain: no new grants, no stall; everything expected must be consumed.
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("drain_valid", ID_valid_o, 32'd0);
    checkOutput("drain_queue_empty", exp_q.size(), 32'd0);
    checkOutput("progress", {31'd0, (consumed > 200)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
